// File: rtl/rr_arb2_pkg.sv
// Shared constants and types for the two-source round-robin arbiter stage.
package rr_arb2_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Output register occupancy; the encoding doubles as y_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Pretending B won last makes A the first winner after reset.
  localparam logic RST_LAST_GRANT = SRC_B;

endpackage

// File: rtl/rr_arb2_stage_mux2_w.sv
// WIDTH-bit 2:1 data select driven by the combinational grant.
module mux2_w #(
  parameter int WIDTH = 2
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/rr_arb2_stage.sv
// Two-source round-robin arbiter feeding a registered output word plus select.
module rr_arb2_stage
  import rr_arb2_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y,
  output logic             sel,
  input  logic             y_ready
);

  state_t           state_p0;
  state_t           state_nxt;
  logic [WIDTH-1:0] y_p0;
  logic             sel_p0;
  logic             last_grant_p0;

  logic             load;
  logic             grant_vld;
  logic             grant_idx;
  logic [WIDTH-1:0] grant_data;

  assign y_valid = (state_p0 == ST_FULL);
  assign y       = y_p0;
  assign sel     = sel_p0;

  // The register can take a new word whenever it is empty or being drained now.
  assign load = !y_valid || y_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = SRC_A;
    if (load) begin
      if (a_valid && b_valid) begin
        grant_vld = 1'b1;
        grant_idx = ~last_grant_p0;
      end else if (a_valid) begin
        grant_vld = 1'b1;
        grant_idx = SRC_A;
      end else if (b_valid) begin
        grant_vld = 1'b1;
        grant_idx = SRC_B;
      end
    end
  end

  // Readies are forced low while reset is held so no source sees a false take.
  assign a_ready = rst_n && grant_vld && (grant_idx == SRC_A);
  assign b_ready = rst_n && grant_vld && (grant_idx == SRC_B);

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_EMPTY: if (grant_vld) state_nxt = ST_FULL;
      ST_FULL:  if (y_ready && !grant_vld) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .sel (grant_idx),
    .d0  (a_data),
    .d1  (b_data),
    .y   (grant_data)
  );

  // Stage p0: output register and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0      <= ST_EMPTY;
      y_p0          <= '0;
      sel_p0        <= SRC_A;
      last_grant_p0 <= RST_LAST_GRANT;
    end else begin
      state_p0 <= state_nxt;
      if (grant_vld) begin
        y_p0          <= grant_data;
        sel_p0        <= grant_idx;
        last_grant_p0 <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb2_stage.sv
// Directed and randomized checks of rr_arb2_stage against a behavioural model.
module tb_rr_arb2_stage;

  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y;
  logic             sel;
  logic             y_ready;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the consumer should see, and who won last.
  int exp_vld;
  int exp_y;
  int exp_sel;
  int exp_last;

  rr_arb2_stage #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y       (y),
    .sel     (sel),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_vld  = 0;
    exp_y    = 0;
    exp_sel  = 0;
    exp_last = 1;
  endtask

  task automatic drive(input logic av, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [WIDTH-1:0] bd, input logic yr);
    a_valid = av;
    a_data  = ad;
    b_valid = bv;
    b_data  = bd;
    y_ready = yr;
  endtask

  // One clock: check readies before the edge, apply the model, check outputs after.
  task automatic tick(input string tag);
    int g;
    int gdata;
    bit load;
    load = (exp_vld == 0) || y_ready;
    g = -1;
    if (load) begin
      if (a_valid && b_valid) g = (exp_last == 0) ? 1 : 0;
      else if (a_valid)       g = 0;
      else if (b_valid)       g = 1;
    end
    gdata = (g == 1) ? int'(b_data) : int'(a_data);
    #1;
    check({tag, ".a_ready"}, a_ready, (g == 0) ? 1 : 0);
    check({tag, ".b_ready"}, b_ready, (g == 1) ? 1 : 0);
    @(posedge clk);
    if (g >= 0) begin
      exp_vld  = 1;
      exp_y    = gdata;
      exp_sel  = g;
      exp_last = g;
    end else if (load) begin
      exp_vld = 0;
    end
    #1;
    check({tag, ".y_valid"}, y_valid, exp_vld);
    check({tag, ".y"}, y, exp_y);
    check({tag, ".sel"}, sel, exp_sel);
  endtask

  // Pulse reset in the middle of a cycle and confirm outputs clear at once.
  task automatic mid_reset(input string tag);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".y_valid"}, y_valid, 0);
    check({tag, ".y"}, y, 0);
    check({tag, ".sel"}, sel, 0);
    check({tag, ".a_ready"}, a_ready, 0);
    check({tag, ".b_ready"}, b_ready, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    check("por.y_valid", y_valid, 0);
    check("por.y", y, 0);
    check("por.sel", sel, 0);
    check("por.a_ready", a_ready, 0);
    check("por.b_ready", b_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with b=10 and stall, then reset with the word held.
    drive(1'b0, 2'b00, 1'b1, 2'b10, 1'b0);
    tick("fill_b");
    check("fill_b.y_const", y, 2'b10);
    drive(1'b1, 2'b01, 1'b1, 2'b11, 1'b0);
    mid_reset("rst_mid");
    drive(1'b1, 2'b01, 1'b1, 2'b11, 1'b1);
    tick("rst_first");
    check("rst_first.sel_const", sel, 0);

    // Single source a
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b1);
    tick("single_a");
    check("single_a.y_const", y, 2'b01);

    // Drain to empty, then a lone b word
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    tick("drain");
    check("drain.y_valid_const", y_valid, 0);
    drive(1'b0, 2'b00, 1'b1, 2'b10, 1'b1);
    tick("late_b");
    check("late_b.sel_const", sel, 1);

    // Contention: expect a,b,a,b then one more a to leave y=11 in place
    drive(1'b1, 2'b11, 1'b1, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick("contend");
      check("contend.sel_const", sel, (i % 2 == 0) ? 0 : 1);
    end
    tick("contend5");
    check("contend5.y_const", y, 2'b11);

    // Backpressure for 3 cycles, then b must be served
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall.y_const", y, 2'b11);
    y_ready = 1'b1;
    tick("unstall");
    check("unstall.sel_const", sel, 1);

    // Grant a, idle twice, then contention goes to b
    drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b1);
    tick("idle_a");
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    tick("idle1");
    tick("idle2");
    drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    tick("idle_both");
    check("idle_both.sel_const", sel, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 63) == 0) mid_reset("rand_rst");
      else tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb2_stage.md
Name: rr_arb2_stage

Overview:
- Two-source round-robin arbiter with a registered output stage.
- Sits directly upstream of the team's 2-bit 2:1 select mux. It decides which source wins each cycle and produces the registered select line and the selected data word.
- Downstream logic consumes both the data word and the select line, together with a valid/ready handshake.

Parameters:
- WIDTH, 2, data width of each source and of the output word.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  source 0 holds a word.
- a_data  input  WIDTH  source 0 word.
- a_ready  output  1  source 0 word is taken this cycle.
- b_valid  input  1  source 1 holds a word.
- b_data  input  WIDTH  source 1 word.
- b_ready  output  1  source 1 word is taken this cycle.
- y_valid  output  1  output register holds a word.
- y  output  WIDTH  registered selected word.
- sel  output  1  registered source index of y (0 = a, 1 = b).
- y_ready  input  1  downstream accepts y this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): y_valid=0, y=0, sel=0, last_grant=1, so source 0 has first priority. a_ready and b_ready are 0 while in reset.
- load = !y_valid || y_ready. Load is combinational, so the output register refills in the same cycle it drains; full throughput is 1 word per cycle.
- Grant (combinational, evaluated only when load=1):
  - Only a_valid: grant a.
  - Only b_valid: grant b.
  - Both valid: grant the source that is not last_grant.
  - Neither valid: no grant.
- a_ready = load && grant==a. b_ready = load && grant==b.
- The ready signals depend only on valid inputs, y_valid and y_ready, never on data. There are no combinational loops.
- On a clock edge with a grant: y <= granted data; sel <= granted index; y_valid <= 1; last_grant <= granted index.
- On a clock edge with load=1 and no grant: y_valid <= 0. y and sel hold their previous values (don't-care to the consumer).
- On a clock edge with load=0 (y_valid=1 and y_ready=0): y, sel, y_valid and last_grant all hold. Both ready outputs stay 0 (backpressure).
- Latency: a word accepted at edge N is visible on y, sel and y_valid after edge N.
- last_grant changes only on an actual transfer. An idle cycle or a stalled cycle never rotates priority.
- Sources must hold valid and data stable until their ready is seen. The block does not check this.
- Reset mid-operation: any word in the output register is dropped. Priority returns to source 0.
- State machine, 2 states, encoded by y_valid:
  - EMPTY --grant--> FULL.
  - FULL --y_ready and grant--> FULL.
  - FULL --y_ready and no grant--> EMPTY.
  - FULL --!y_ready--> FULL (stall).
- Width rule: y is exactly WIDTH bits with no extension or truncation. sel is always 1 bit.

Decomposition:
- Shared package rr_arb2_pkg holds:
  - Source index constants SRC_A=1'b0 and SRC_B=1'b1.
  - State constants ST_EMPTY and ST_FULL.
  - Reset-priority constant RST_LAST_GRANT=SRC_B.
- One sub-module, mux2_w (WIDTH-bit 2:1 data select), picks a_data or b_data from the combinational grant ahead of the output register.

Test Plan:
- Reset during traffic: with y_valid=1 and y=2'b10, assert rst_n=0 mid-cycle -> y_valid, y and sel go to 0 immediately, and a_ready and b_ready go to 0. After release with both sources valid, source a wins first.
- Single source: only a_valid=1 with a_data=2'b01, y_ready=1 held -> a_ready=1. After the edge, y=2'b01, sel=0, y_valid=1.
- Contention alternation: a_valid and b_valid held at 1, a_data=2'b11, b_data=2'b10, y_ready=1 for 4 cycles -> the sel sequence is 0,1,0,1 and y is 11,10,11,10.
- Backpressure: output full with y=2'b11 and y_ready=0 for 3 cycles while both sources are valid -> a_ready and b_ready stay 0, and y, sel and y_valid are unchanged. Priority does not rotate: when y_ready returns to 1, the source not granted last is served.
- Drain to empty: y_valid=1, y_ready=1, neither source valid -> y_valid=0 next cycle. A later b_valid with b_data=2'b10 -> y=2'b10 and sel=1 one cycle after acceptance.
- Idle does not rotate priority: grant a, then 2 idle cycles, then both sources valid -> b is granted.
